// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU (A) and the load/FP unit (B),
// with a pending-write scoreboard for read-after-write hazard detection and a saturating conflict counter.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rf_regWrite,
    output logic [ADDR_W-1:0] rf_writeReg,
    output logic [DATA_W-1:0] rf_writeData,
    input  logic              claim_valid,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic [ADDR_W-1:0] chk_addr1,
    input  logic [ADDR_W-1:0] chk_addr2,
    output logic              chk_busy1,
    output logic              chk_busy2,
    output logic [31:0]       pending,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic              last_grant_b_q, last_grant_b_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_reg_q, rf_reg_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic [31:0]       pending_q, pending_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       set_mask, clr_mask;
    logic              grant_a, grant_b;

    // On a tie, the port that did not win last time is granted.
    always_comb begin
        grant_a = a_valid && (!b_valid || last_grant_b_q);
        grant_b = b_valid && (!a_valid || !last_grant_b_q);
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_comb begin
        last_grant_b_d = last_grant_b_q;
        rf_we_d        = 1'b0;
        rf_reg_d       = rf_reg_q;
        rf_data_d      = rf_data_q;
        if (grant_a) begin
            last_grant_b_d = 1'b0;
            rf_we_d        = (a_addr != '0);
            rf_reg_d       = a_addr;
            rf_data_d      = a_data;
        end else if (grant_b) begin
            last_grant_b_d = 1'b1;
            rf_we_d        = (b_addr != '0);
            rf_reg_d       = b_addr;
            rf_data_d      = b_data;
        end
    end

    // A fresh claim beats the clear from a write landing on the same edge.
    always_comb begin
        set_mask  = '0;
        clr_mask  = '0;
        if (claim_valid && (claim_addr != '0)) begin
            set_mask = 32'd1 << claim_addr;
        end
        if (rf_we_q) begin
            clr_mask = 32'd1 << rf_reg_q;
        end
        pending_d = ((pending_q & ~clr_mask) | set_mask) & ~32'd1;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (a_valid && b_valid && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_b_q <= 1'b1;
            rf_we_q        <= 1'b0;
            rf_reg_q       <= '0;
            rf_data_q      <= '0;
            pending_q      <= '0;
            cnt_q          <= '0;
        end else begin
            last_grant_b_q <= last_grant_b_d;
            rf_we_q        <= rf_we_d;
            rf_reg_q       <= rf_reg_d;
            rf_data_q      <= rf_data_d;
            pending_q      <= pending_d;
            cnt_q          <= cnt_d;
        end
    end

    assign rf_regWrite  = rf_we_q;
    assign rf_writeReg  = rf_reg_q;
    assign rf_writeData = rf_data_q;
    assign pending      = pending_q;
    assign conflict_cnt = cnt_q;
    assign chk_busy1    = pending_q[chk_addr1];
    assign chk_busy2    = pending_q[chk_addr2];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              a_valid, b_valid, claim_valid;
    logic [ADDR_W-1:0] a_addr, b_addr, claim_addr, chk_addr1, chk_addr2;
    logic [DATA_W-1:0] a_data, b_data;
    logic              a_ready, b_ready, rf_regWrite, chk_busy1, chk_busy2;
    logic [ADDR_W-1:0] rf_writeReg;
    logic [DATA_W-1:0] rf_writeData;
    logic [31:0]       pending;
    logic [CNT_W-1:0]  conflict_cnt;

    int total = 0;
    int bad   = 0;

    regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rf_regWrite(rf_regWrite), .rf_writeReg(rf_writeReg), .rf_writeData(rf_writeData),
        .claim_valid(claim_valid), .claim_addr(claim_addr),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
        .pending(pending), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: who won last, what sits on the write port, which registers are reserved.
    bit                m_last_b;
    bit                m_we;
    logic [ADDR_W-1:0] m_reg;
    logic [DATA_W-1:0] m_data;
    bit                m_pend [32];
    int                m_cnt;

    function automatic int pick();
        if (a_valid && b_valid) return m_last_b ? 1 : 2;
        if (a_valid) return 1;
        if (b_valid) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] pend_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        m_last_b = 1'b1;
        m_we     = 1'b0;
        m_reg    = '0;
        m_data   = '0;
        m_cnt    = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    endtask

    task automatic model_step();
        int g;
        g = pick();
        if (a_valid && b_valid && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (m_we) m_pend[m_reg] = 1'b0;
        if (claim_valid && claim_addr != 0) m_pend[claim_addr] = 1'b1;
        m_pend[0] = 1'b0;
        if (g == 1) begin
            m_we = (a_addr != 0); m_reg = a_addr; m_data = a_data; m_last_b = 1'b0;
        end else if (g == 2) begin
            m_we = (b_addr != 0); m_reg = b_addr; m_data = b_data; m_last_b = 1'b1;
        end else begin
            m_we = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; claim_valid = 0;
        a_addr = '0; b_addr = '0; claim_addr = '0; chk_addr1 = '0; chk_addr2 = '0;
        a_data = '0; b_data = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        a_valid = 1; a_addr = 5; a_data = 32'hAB;
        b_valid = 1; b_addr = 6; b_data = 32'hCD;
        claim_valid = 1; claim_addr = 7;
        #1;
        total++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            bad++; $display("FAIL reset_first_tie: a_ready=%b b_ready=%b want 1 0", a_ready, b_ready);
        end
        @(posedge clk); #1;
        idle_inputs();
        total++;
        if (rf_regWrite !== 1'b1 || rf_writeReg !== 5'd5) begin
            bad++; $display("FAIL reset_prewrite: we=%b reg=%0d want 1 5", rf_regWrite, rf_writeReg);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (rf_regWrite !== 0 || rf_writeReg !== 0 || rf_writeData !== 0 || pending !== 0
            || conflict_cnt !== 0 || a_ready !== 0 || b_ready !== 0) begin
            bad++; $display("FAIL reset_async: we=%b reg=%0d data=%h pend=%h cnt=%0d ar=%b br=%b want all 0",
                            rf_regWrite, rf_writeReg, rf_writeData, pending, conflict_cnt, a_ready, b_ready);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        a_valid = 1; a_addr = 3; a_data = 32'h11;
        #1;
        total++;
        if (a_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready: a_ready=%b want 1", a_ready);
        end
        @(posedge clk); #1;
        a_valid = 0;
        total++;
        if (rf_regWrite !== 1'b1 || rf_writeReg !== 5'd3 || rf_writeData !== 32'h11) begin
            bad++; $display("FAIL reset_release_write: we=%b reg=%0d data=%h want 1 3 11",
                            rf_regWrite, rf_writeReg, rf_writeData);
        end
    endtask

    task automatic test_round_robin();
        logic [ADDR_W-1:0] want_reg;
        apply_reset();
        a_valid = 1; a_addr = 8; a_data = 32'hA8;
        b_valid = 1; b_addr = 9; b_data = 32'hB9;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
                bad++; $display("FAIL rr_ready[%0d]: a_ready=%b b_ready=%b", i, a_ready, b_ready);
            end
            @(posedge clk); #1;
            want_reg = (i % 2 == 0) ? 5'd8 : 5'd9;
            total++;
            if (rf_regWrite !== 1'b1 || rf_writeReg !== want_reg) begin
                bad++; $display("FAIL rr_write[%0d]: we=%b reg=%0d want 1 %0d", i, rf_regWrite, rf_writeReg, want_reg);
            end
        end
        idle_inputs();
        total++;
        if (conflict_cnt !== 4'd4) begin
            bad++; $display("FAIL rr_conflict: cnt=%0d want 4", conflict_cnt);
        end
    endtask

    task automatic test_zero_reg();
        apply_reset();
        claim_valid = 1; claim_addr = 20;
        @(posedge clk); #1;
        claim_valid = 0;
        b_valid = 1; b_addr = 0; b_data = 32'hFFFF_FFFF;
        #1;
        total++;
        if (b_ready !== 1'b1) begin
            bad++; $display("FAIL zero_ready: b_ready=%b want 1", b_ready);
        end
        @(posedge clk); #1;
        b_valid = 0;
        total++;
        if (rf_regWrite !== 1'b0 || pending !== 32'h0010_0000) begin
            bad++; $display("FAIL zero_discard: we=%b pend=%h want 0 00100000", rf_regWrite, pending);
        end
        @(posedge clk); #1;
        total++;
        if (pending !== 32'h0010_0000 || rf_regWrite !== 1'b0) begin
            bad++; $display("FAIL zero_after: we=%b pend=%h want 0 00100000", rf_regWrite, pending);
        end
    endtask

    task automatic test_scoreboard();
        apply_reset();
        chk_addr1 = 16; chk_addr2 = 0;
        claim_valid = 1; claim_addr = 16;
        @(posedge clk); #1;
        claim_valid = 0;
        total++;
        if (pending !== 32'h0001_0000 || chk_busy1 !== 1'b1 || chk_busy2 !== 1'b0) begin
            bad++; $display("FAIL sb_claim: pend=%h busy1=%b busy2=%b want 00010000 1 0", pending, chk_busy1, chk_busy2);
        end
        b_valid = 1; b_addr = 16; b_data = 32'h1234;
        #1;
        total++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            bad++; $display("FAIL sb_ready: b_ready=%b a_ready=%b want 1 0", b_ready, a_ready);
        end
        @(posedge clk); #1;
        b_valid = 0;
        total++;
        if (rf_regWrite !== 1'b1 || rf_writeReg !== 5'd16 || rf_writeData !== 32'h1234 || chk_busy1 !== 1'b1) begin
            bad++; $display("FAIL sb_inflight: we=%b reg=%0d data=%h busy1=%b want 1 16 1234 1",
                            rf_regWrite, rf_writeReg, rf_writeData, chk_busy1);
        end
        @(posedge clk); #1;
        total++;
        if (chk_busy1 !== 1'b0 || pending !== 32'h0 || rf_regWrite !== 1'b0 || rf_writeReg !== 5'd16) begin
            bad++; $display("FAIL sb_cleared: busy1=%b pend=%h we=%b reg=%0d want 0 0 0 16",
                            chk_busy1, pending, rf_regWrite, rf_writeReg);
        end
    endtask

    task automatic test_set_clear();
        apply_reset();
        chk_addr2 = 17;
        claim_valid = 1; claim_addr = 17;
        @(posedge clk); #1;
        claim_valid = 0;
        b_valid = 1; b_addr = 17; b_data = 32'h77;
        @(posedge clk); #1;
        b_valid = 0;
        claim_valid = 1; claim_addr = 17;
        total++;
        if (rf_regWrite !== 1'b1 || rf_writeReg !== 5'd17) begin
            bad++; $display("FAIL sc_write: we=%b reg=%0d want 1 17", rf_regWrite, rf_writeReg);
        end
        @(posedge clk); #1;
        claim_valid = 0;
        total++;
        if (pending !== 32'h0002_0000 || chk_busy2 !== 1'b1) begin
            bad++; $display("FAIL sc_set_wins: pend=%h busy2=%b want 00020000 1", pending, chk_busy2);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        a_valid = 1; a_addr = 1; b_valid = 1; b_addr = 2;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
        end
        idle_inputs();
        total++;
        if (conflict_cnt !== 4'hF) begin
            bad++; $display("FAIL sat_cnt: cnt=%0d want 15", conflict_cnt);
        end
        @(posedge clk); #1;
        total++;
        if (conflict_cnt !== 4'hF) begin
            bad++; $display("FAIL sat_hold: cnt=%0d want 15", conflict_cnt);
        end
    endtask

    task automatic test_random();
        int  g;
        bit  a_hold, b_hold;
        apply_reset();
        a_hold = 0; b_hold = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!a_hold) begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_addr  = ADDR_W'($urandom_range(0, 31));
                a_data  = $urandom;
            end
            if (!b_hold) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_addr  = ADDR_W'($urandom_range(0, 31));
                b_data  = $urandom;
            end
            claim_valid = ($urandom_range(0, 2) == 0);
            claim_addr  = ADDR_W'($urandom_range(0, 31));
            chk_addr1   = ADDR_W'($urandom_range(0, 31));
            chk_addr2   = ADDR_W'($urandom_range(0, 31));
            #1;
            g = pick();
            total++;
            if (a_ready !== (g == 1) || b_ready !== (g == 2)
                || chk_busy1 !== m_pend[chk_addr1] || chk_busy2 !== m_pend[chk_addr2]) begin
                bad++; $display("FAIL rand_comb[%0d]: ar=%b br=%b b1=%b b2=%b want %b %b %b %b", cyc,
                                a_ready, b_ready, chk_busy1, chk_busy2, g == 1, g == 2,
                                m_pend[chk_addr1], m_pend[chk_addr2]);
            end
            a_hold = a_valid && (g != 1);
            b_hold = b_valid && (g != 2);
            @(posedge clk);
            model_step();
            #1;
            total++;
            if (rf_regWrite !== m_we || rf_writeReg !== m_reg || rf_writeData !== m_data
                || pending !== pend_vec() || conflict_cnt !== CNT_W'(m_cnt)) begin
                bad++; $display("FAIL rand_state[%0d]: we=%b reg=%0d data=%h pend=%h cnt=%0d want %b %0d %h %h %0d",
                                cyc, rf_regWrite, rf_writeReg, rf_writeData, pending, conflict_cnt,
                                m_we, m_reg, m_data, pend_vec(), m_cnt);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_round_robin();
        test_zero_reg();
        test_scoreboard();
        test_set_clear();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
